// File: rtl/usbf_tx_crc_append.sv
// usbf_tx_crc_append
//   Transmit-side byte stream shim for a USB function. Passes payload bytes
//   through a one-deep output register and appends the inverted USB CRC16
//   (low byte first) after the last payload byte. A zero-length-packet
//   request produces only the two CRC bytes.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake
//   in_data_i              payload byte (ignored for a ZLP request)
//   in_last_i              final payload byte of the packet
//   in_zlp_i               packet has no payload (only honoured in IDLE)
//   out_valid_o/out_ready_i downstream handshake (registered outputs)
//   out_data_o             payload or CRC byte
//   out_last_o             marks the second (high) CRC byte
//   abort_i                drop the current packet, highest priority
//   busy_o                 packet in flight or output byte pending
//   byte_count_o           payload bytes of current/last packet, saturating
//
// Also contains usbf_crc16, the combinational one-byte CRC16 step.

module usbf_crc16 (
  input  logic [15:0] crc_in_i,
  input  logic [7:0]  din_i,
  output logic [15:0] crc_out_o
);

  logic [15:0] w_crc;

  // Reflected form of x^16+x^15+x^2+1, data consumed LSB first.
  always_comb begin
    w_crc = crc_in_i;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0] ^ din_i[i]) w_crc = (w_crc >> 1) ^ 16'hA001;
      else                      w_crc = w_crc >> 1;
    end
    crc_out_o = w_crc;
  end

endmodule

// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for first byte or ZLP request; crc holds CRC_INIT
// S_DATA   | mid-packet, accepting payload bytes
// S_CRC_LO | payload done, load ~crc[7:0] when output slot is free
// S_CRC_HI | load ~crc[15:8] with out_last_o, then back to IDLE
module usbf_tx_crc_append #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  input  logic        in_zlp_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic [10:0] byte_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;
  logic [15:0] w_crc_upd;
  logic        r_out_valid;
  logic        w_out_valid_nxt;
  logic [7:0]  r_out_data;
  logic [7:0]  w_out_data_nxt;
  logic        r_out_last;
  logic        w_out_last_nxt;
  logic [10:0] r_byte_count;
  logic [10:0] w_byte_count_nxt;
  logic [10:0] w_byte_count_inc;
  logic        w_free;
  logic        w_accept;

  // r_crc is CRC_INIT whenever the FSM sits in IDLE (reset, abort and
  // CRC_HI all restore it), so the first byte can use r_crc directly.
  usbf_crc16 u_crc16 (
    .crc_in_i  (r_crc),
    .din_i     (in_data_i),
    .crc_out_o (w_crc_upd)
  );

  assign w_free     = !r_out_valid || out_ready_i;
  assign in_ready_o = ((r_state == S_IDLE) || (r_state == S_DATA)) && w_free && !abort_i;
  assign w_accept   = in_valid_i && in_ready_o;

  assign w_byte_count_inc = (r_byte_count == 11'h7FF) ? r_byte_count : r_byte_count + 11'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_crc_nxt        = r_crc;
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_out_last_nxt   = r_out_last;
    w_byte_count_nxt = r_byte_count;

    if (abort_i) begin
      w_state_nxt     = S_IDLE;
      w_crc_nxt       = CRC_INIT;
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end else if (w_free) begin
      // Slot drains this cycle; it stays empty unless something loads below.
      w_out_valid_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (in_zlp_i) begin
              w_crc_nxt        = CRC_INIT;
              w_byte_count_nxt = 11'd0;
              w_state_nxt      = S_CRC_LO;
            end else begin
              w_crc_nxt        = w_crc_upd;
              w_out_valid_nxt  = 1'b1;
              w_out_data_nxt   = in_data_i;
              w_out_last_nxt   = 1'b0;
              w_byte_count_nxt = 11'd1;
              w_state_nxt      = in_last_i ? S_CRC_LO : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            w_crc_nxt        = w_crc_upd;
            w_out_valid_nxt  = 1'b1;
            w_out_data_nxt   = in_data_i;
            w_out_last_nxt   = 1'b0;
            w_byte_count_nxt = w_byte_count_inc;
            if (in_last_i) w_state_nxt = S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = ~r_crc[7:0];
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = S_CRC_HI;
        end
        S_CRC_HI: begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = ~r_crc[15:8];
          w_out_last_nxt  = 1'b1;
          w_crc_nxt       = CRC_INIT;
          w_state_nxt     = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_crc        <= CRC_INIT;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_last   <= 1'b0;
      r_byte_count <= 11'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_crc        <= w_crc_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_last   <= w_out_last_nxt;
      r_byte_count <= w_byte_count_nxt;
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign out_last_o   = r_out_last;
  assign byte_count_o = r_byte_count;
  assign busy_o       = (r_state != S_IDLE) || r_out_valid;

endmodule

// File: tb/tb_usbf_tx_crc_append.sv
module tb_usbf_tx_crc_append;

  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] oq_t[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        z;
    logic        r;
    logic        a;
    logic        e_rdy;
    logic        e_ov;
    logic        chk_d;
    logic [7:0]  e_od;
    logic        e_ol;
    logic        e_busy;
    logic [10:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_last_i;
  logic        in_zlp_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        out_ready_i;
  logic        abort_i;
  logic        busy_o;
  logic [10:0] byte_count_o;

  logic r_ordy = 1'b1;
  logic r_rand = 1'b1;
  logic rand_en = 1'b0;
  assign out_ready_i = rand_en ? r_rand : r_ordy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  oq_t outq;
  int  outt[$];

  usbf_tx_crc_append dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .in_zlp_i     (in_zlp_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .byte_count_o (byte_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    r_rand = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Output collector and hold checker, both sampled mid-cycle.
  logic       p_stall = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       p_last = 1'b0;
  logic       p_ok = 1'b0;
  always @(negedge clk) begin
    cyc_n++;
    if (rst_ni && !abort_i && out_valid_o && out_ready_i) begin
      outq.push_back({out_last_o, out_data_o});
      outt.push_back(cyc_n);
    end
    if (p_stall && p_ok) begin
      chk("hold_valid", 32'(out_valid_o), 32'd1);
      chk("hold_data", 32'(out_data_o), 32'(p_data));
      chk("hold_last", 32'(out_last_o), 32'(p_last));
    end
    p_stall = out_valid_o && !out_ready_i;
    p_data  = out_data_o;
    p_last  = out_last_o;
    p_ok    = rst_ni && !abort_i;
  end

  // Model uses the non-reflected register with poly 0x8005; its bit
  // reversal equals the LSB-first register used on the wire.
  function automatic logic [15:0] crc_model(input bq_t b);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ b[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  function automatic oq_t build_exp(input bq_t b);
    oq_t         q;
    logic [15:0] c;
    q = {};
    foreach (b[k]) q.push_back({1'b0, b[k]});
    c = crc_model(b);
    q.push_back({1'b0, c[7:0]});
    q.push_back({1'b1, c[15:8]});
    return q;
  endfunction

  function automatic vec_t mk(input bit v, input bit [7:0] d, input bit l, input bit z,
                              input bit r, input bit a, input bit er, input bit eov,
                              input bit cd, input bit [7:0] eod, input bit eol,
                              input bit eb, input bit [10:0] ec);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.z = z; x.r = r; x.a = a;
    x.e_rdy = er; x.e_ov = eov; x.chk_d = cd; x.e_od = eod; x.e_ol = eol;
    x.e_busy = eb; x.e_cnt = ec;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input logic z, input string nm);
    bit ok;
    ok = 0;
    in_valid_i = 1'b1;
    in_data_i  = b;
    in_last_i  = l;
    in_zlp_i   = z;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready_o) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) fail_to(nm);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    in_zlp_i   = 1'b0;
  endtask

  task automatic send_pkt(input bq_t b, input string nm);
    foreach (b[k]) send_byte(b[k], (k == b.size() - 1), 1'b0, nm);
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (!busy_o) done = 1;
    end
    if (!done) fail_to(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_q(input string nm, input oq_t act, input oq_t exp);
    chk($sformatf("%s_len", nm), 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), 32'(act[i]), 32'(exp[i]));
  endtask

  vec_t        tbl[12];
  bq_t         b4, b9, bp, b1, b2;
  oq_t         q1, e;
  logic [15:0] crc4;

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; in_last_i = 1'b0;
    in_zlp_i = 1'b0; abort_i = 1'b0;

    b4   = '{8'h00, 8'h01, 8'h02, 8'h03};
    crc4 = crc_model(b4);
    //            v  d     l  z  r  a  rdy ov cd od          ol eb cnt
    tbl[0]  = mk(1, 8'h00, 0, 1, 1, 0, 1,  0, 0, 8'h00,      0, 1, 0);
    tbl[1]  = mk(0, 8'h00, 0, 0, 1, 0, 0,  1, 1, 8'h00,      0, 1, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 1, 0, 0,  1, 1, 8'h00,      1, 1, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 1, 0, 1,  0, 0, 8'h00,      0, 0, 0);
    tbl[4]  = mk(1, 8'h00, 0, 0, 1, 0, 1,  1, 1, 8'h00,      0, 1, 1);
    tbl[5]  = mk(1, 8'h01, 0, 0, 1, 0, 1,  1, 1, 8'h01,      0, 1, 2);
    tbl[6]  = mk(1, 8'h02, 0, 0, 0, 0, 0,  1, 1, 8'h01,      0, 1, 2);
    tbl[7]  = mk(1, 8'h02, 0, 0, 1, 0, 1,  1, 1, 8'h02,      0, 1, 3);
    tbl[8]  = mk(1, 8'h03, 1, 0, 1, 0, 1,  1, 1, 8'h03,      0, 1, 4);
    tbl[9]  = mk(0, 8'h00, 0, 0, 1, 0, 0,  1, 1, crc4[7:0],  0, 1, 4);
    tbl[10] = mk(0, 8'h00, 0, 0, 1, 0, 0,  1, 1, crc4[15:8], 1, 1, 4);
    tbl[11] = mk(0, 8'h00, 0, 0, 1, 0, 1,  0, 0, 8'h00,      0, 0, 4);

    // reset values
    repeat (3) cyc();
    chk("rst_ov", 32'(out_valid_o), 0);
    chk("rst_od", 32'(out_data_o), 0);
    chk("rst_ol", 32'(out_last_o), 0);
    chk("rst_cnt", 32'(byte_count_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_ni = 1'b1;
    cyc();
    chk("rst_rdy", 32'(in_ready_o), 1);

    // ZLP then 4-byte packet with one stall, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      in_valid_i = tbl[i].v; in_data_i = tbl[i].d; in_last_i = tbl[i].l;
      in_zlp_i = tbl[i].z; r_ordy = tbl[i].r; abort_i = tbl[i].a;
      @(negedge clk);
      chk($sformatf("t%0d_rdy", i), 32'(in_ready_o), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_ov", i), 32'(out_valid_o), 32'(tbl[i].e_ov));
      chk($sformatf("t%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
      chk($sformatf("t%0d_cnt", i), 32'(byte_count_o), 32'(tbl[i].e_cnt));
      if (tbl[i].chk_d) begin
        chk($sformatf("t%0d_od", i), 32'(out_data_o), 32'(tbl[i].e_od));
        chk($sformatf("t%0d_ol", i), 32'(out_last_o), 32'(tbl[i].e_ol));
      end
    end
    in_valid_i = 1'b0; in_last_i = 1'b0; in_zlp_i = 1'b0; r_ordy = 1'b1;

    // catalogue check value of CRC-16/USB over "123456789" is 0xB4C8
    b9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    outq.delete();
    send_pkt(b9, "chkval");
    drain("chkval_drain");
    chk("chkval_len", 32'(outq.size()), 11);
    if (outq.size() == 11) begin
      chk("chkval_lo", 32'(outq[9]), 32'h0C8);
      chk("chkval_hi", 32'(outq[10]), 32'h1B4);
    end
    chk("chkval_cnt", 32'(byte_count_o), 9);

    // back-to-back single-byte packets
    b1 = '{8'hA5};
    b2 = '{8'h5A};
    outq.delete();
    outt.delete();
    send_pkt(b1, "b2b_1");
    send_pkt(b2, "b2b_2");
    drain("b2b_drain");
    e = build_exp(b1);
    foreach (b2[k]) begin end
    begin
      oq_t e2;
      e2 = build_exp(b2);
      foreach (e2[k]) e.push_back(e2[k]);
    end
    cmp_q("b2b", outq, e);
    if (outt.size() == 6) chk("b2b_gapless", 32'(outt[5] - outt[0]), 5);

    // 64-byte packet, reference run then random backpressure
    bp = {};
    for (int i = 0; i < 64; i++) bp.push_back(8'($urandom_range(0, 255)));
    outq.delete();
    send_pkt(bp, "bp_ref");
    drain("bp_ref_drain");
    q1 = outq;
    cmp_q("bp_ref", q1, build_exp(bp));
    chk("bp_cnt", 32'(byte_count_o), 64);
    outq.delete();
    rand_en = 1'b1;
    send_pkt(bp, "bp_stall");
    drain("bp_stall_drain");
    rand_en = 1'b0;
    cmp_q("bp_stall", outq, q1);

    // abort after 3 of 8 bytes
    for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0, "abort_data");
    in_valid_i = 1'b1; in_data_i = 8'h13; abort_i = 1'b1;
    @(negedge clk);
    chk("abort_rdy", 32'(in_ready_o), 0);
    @(posedge clk);
    #1;
    abort_i = 1'b0; in_valid_i = 1'b0;
    chk("abort_ov", 32'(out_valid_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_cnt", 32'(byte_count_o), 3);
    outq.delete();
    b1 = '{8'h42};
    send_pkt(b1, "post_abort");
    drain("post_abort_drain");
    cmp_q("post_abort", outq, build_exp(b1));
    outq.delete();
    send_byte(8'h77, 1'b0, 1'b1, "zlp");
    drain("zlp_drain");
    e = '{9'h000, 9'h100};
    cmp_q("zlp", outq, e);
    chk("zlp_cnt", 32'(byte_count_o), 0);

    // reset while in CRC_LO
    send_byte(8'h3C, 1'b1, 1'b0, "rst_mid");
    rst_ni = 1'b0;
    cyc();
    chk("rstmid_ov", 32'(out_valid_o), 0);
    chk("rstmid_od", 32'(out_data_o), 0);
    chk("rstmid_ol", 32'(out_last_o), 0);
    chk("rstmid_cnt", 32'(byte_count_o), 0);
    chk("rstmid_busy", 32'(busy_o), 0);
    outq.delete();
    rst_ni = 1'b1;
    cyc();
    chk("rstmid_rdy", 32'(in_ready_o), 1);
    repeat (5) cyc();
    chk("rstmid_noout", 32'(outq.size()), 0);

    // byte counter saturation
    for (int i = 0; i < 2049; i++) begin
      send_byte(8'(i), (i == 2048), 1'b0, "sat");
      if (i == 2045) chk("sat_2046", 32'(byte_count_o), 2046);
    end
    drain("sat_drain");
    chk("sat_cnt", 32'(byte_count_o), 2047);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
